// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - two-requester round-robin front end for one shared divider
//
// Purpose:
//   Shares a single multi-cycle divider between two requesters.
//   Only one operation is in flight at a time. The block sequences each
//   operation through IDLE -> LAUNCH -> WAIT -> RESP. A watchdog aborts an
//   operation whose divider never reports completion.
//
// Parameters:
//   TIMEOUT_CYC   maximum WAIT cycles before the operation is aborted with rsp_err=1
//   ID_W          width of rsp_id
//
// Ports:
//   clk, nreset                       clock (rising edge), async active-low reset
//   req_valid[1:0] / req_ready[1:0]   per-requester request / one-hot accept
//   req{0,1}_dividend, req{0,1}_divisor   24-bit operands per requester
//   div_en, div_dividend, div_divisor     start pulse and operands to the divider
//   div_quotient, div_remainder, div_done, div_busy   divider results and status
//   rsp_valid / rsp_ready             result handshake
//   rsp_id, rsp_quotient, rsp_remainder, rsp_err      result payload
//
// Build option:
//   DIV_ZERO_BYPASS_EN   when defined, a zero divisor is answered directly
//                        (quotient all ones, remainder = dividend, rsp_err=1)
//                        without starting the divider.

module div_share_arbiter #(
   parameter int TIMEOUT_CYC = 64,
   parameter int ID_W        = 1
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [23:0]     req0_dividend,
   input  logic [23:0]     req0_divisor,
   input  logic [23:0]     req1_dividend,
   input  logic [23:0]     req1_divisor,
   output logic            div_en,
   output logic [23:0]     div_dividend,
   output logic [23:0]     div_divisor,
   input  logic [51:0]     div_quotient,
   input  logic [23:0]     div_remainder,
   input  logic            div_done,
   input  logic            div_busy,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [ID_W-1:0] rsp_id,
   output logic [51:0]     rsp_quotient,
   output logic [23:0]     rsp_remainder,
   output logic            rsp_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t           state;
   logic             ptr;       // requester favoured when both are valid
   logic             cur_id;    // requester owning the current operation
   logic [CNT_W-1:0] cnt;       // WAIT cycle counter

   logic             grant_id;
   logic [23:0]      sel_dividend;
   logic [23:0]      sel_divisor;

   // A lone requester always wins; the pointer only breaks ties.
   // req_ready and div_en must respond in the same cycle as their inputs,
   // so they are decoded from the state rather than registered.
   always_comb begin
      grant_id     = (req_valid == 2'b11) ? ptr : req_valid[1];
      sel_dividend = grant_id ? req1_dividend : req0_dividend;
      sel_divisor  = grant_id ? req1_divisor  : req0_divisor;
      req_ready    = 2'b00;
      if (state == IDLE && (|req_valid))
         req_ready = grant_id ? 2'b10 : 2'b01;
      div_en       = (state == LAUNCH) && !div_busy;
   end

   assign rsp_valid = (state == RESP);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state         <= IDLE;
         ptr           <= 1'b0;
         cur_id        <= 1'b0;
         cnt           <= '0;
         div_dividend  <= '0;
         div_divisor   <= '0;
         rsp_id        <= '0;
         rsp_quotient  <= '0;
         rsp_remainder <= '0;
         rsp_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  cur_id       <= grant_id;
                  rsp_id       <= ID_W'(grant_id);
                  div_dividend <= sel_dividend;
                  div_divisor  <= sel_divisor;
                  cnt          <= '0;
`ifdef DIV_ZERO_BYPASS_EN
                  if (sel_divisor == 24'd0) begin
                     rsp_quotient  <= '1;
                     rsp_remainder <= sel_dividend;
                     rsp_err       <= 1'b1;
                     state         <= RESP;
                  end else begin
                     state <= LAUNCH;
                  end
`else
                  state <= LAUNCH;
`endif
               end
            end

            LAUNCH: begin
               // div_en is high in exactly the cycle that leaves LAUNCH.
               if (!div_busy) begin
                  cnt   <= '0;
                  state <= WAIT;
               end
            end

            WAIT: begin
               cnt <= cnt + 1'b1;
               // Completion wins over a timeout landing in the same cycle.
               if (div_done) begin
                  rsp_quotient  <= div_quotient;
                  rsp_remainder <= div_remainder;
                  rsp_err       <= 1'b0;
                  state         <= RESP;
               end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  rsp_quotient  <= '0;
                  rsp_remainder <= '0;
                  rsp_err       <= 1'b1;
                  state         <= RESP;
               end
            end

            RESP: begin
               // No grant in the handshake cycle: req_ready is only decoded in IDLE.
               if (rsp_ready) begin
                  ptr   <= ~cur_id;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - directed self-checking bench for div_share_arbiter

module tb_div_share_arbiter;

   logic        clk = 1'b0;
   logic        nreset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [23:0] req0_dividend, req0_divisor, req1_dividend, req1_divisor;
   logic        div_en;
   logic [23:0] div_dividend, div_divisor;
   logic [51:0] div_quotient;
   logic [23:0] div_remainder;
   logic        div_done, div_busy;
   logic        rsp_valid, rsp_ready;
   logic [0:0]  rsp_id;
   logic [51:0] rsp_quotient;
   logic [23:0] rsp_remainder;
   logic        rsp_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   div_share_arbiter #(.TIMEOUT_CYC(64), .ID_W(1)) dut (
      .clk(clk), .nreset(nreset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_dividend(req0_dividend), .req0_divisor(req0_divisor),
      .req1_dividend(req1_dividend), .req1_divisor(req1_divisor),
      .div_en(div_en), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_quotient(div_quotient), .div_remainder(div_remainder),
      .div_done(div_done), .div_busy(div_busy),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err)
   );

   // Advance to 2 time units after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      nreset = 1'b0;
      req_valid = 2'b00; rsp_ready = 1'b0;
      div_done = 1'b0; div_busy = 1'b0;
      div_quotient = '0; div_remainder = '0;
      req0_dividend = '0; req0_divisor = '0;
      req1_dividend = '0; req1_divisor = '0;
      tick();
      nreset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({req_ready, div_en, rsp_valid, rsp_err, rsp_id} !== 6'b0 ||
          rsp_quotient !== 52'd0 || rsp_remainder !== 24'd0 ||
          div_dividend !== 24'd0 || div_divisor !== 24'd0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b en=%b vld=%b err=%b id=%b q=%h r=%h dd=%h dv=%h required all zero",
                  req_ready, div_en, rsp_valid, rsp_err, rsp_id, rsp_quotient, rsp_remainder, div_dividend, div_divisor);
      end
   endtask

   task automatic test_basic();
      do_reset();
      req_valid = 2'b01; req0_dividend = 24'h000064; req0_divisor = 24'h000005;
      #1;
      checks++;
      if (req_ready !== 2'b01 || div_en !== 1'b0) begin
         errors++; $display("FAIL basic_grant: rdy=%b en=%b required rdy=01 en=0", req_ready, div_en);
      end
      tick(); req_valid = 2'b00; #1;
      checks++;
      if (req_ready !== 2'b00 || div_en !== 1'b1 || div_dividend !== 24'h64 || div_divisor !== 24'h5) begin
         errors++; $display("FAIL basic_launch: rdy=%b en=%b dd=%h dv=%h required 00 1 000064 000005",
                            req_ready, div_en, div_dividend, div_divisor);
      end
      tick();
      div_done = 1'b1; div_quotient = 52'd20; div_remainder = 24'd0; #1;
      checks++;
      if (div_en !== 1'b0 || rsp_valid !== 1'b0 || div_dividend !== 24'h64 || div_divisor !== 24'h5) begin
         errors++; $display("FAIL basic_wait: en=%b vld=%b dd=%h dv=%h required 0 0 000064 000005",
                            div_en, rsp_valid, div_dividend, div_divisor);
      end
      tick();
      div_done = 1'b0; div_quotient = 52'h123; div_remainder = 24'h55; #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_quotient !== 52'd20 ||
          rsp_remainder !== 24'd0 || rsp_err !== 1'b0) begin
         errors++; $display("FAIL basic_resp: vld=%b id=%b q=%h r=%h err=%b required 1 0 14 0 0",
                            rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err);
      end
      rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0; #1;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++; $display("FAIL basic_handshake: vld=%b required 0", rsp_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_rdy [4];
      exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
      do_reset();
      req0_dividend = 24'd10; req0_divisor = 24'd2;
      req1_dividend = 24'd30; req1_divisor = 24'd3;
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (req_ready !== exp_rdy[i]) begin
            errors++; $display("FAIL rr_grant[%0d]: rdy=%b required %b", i, req_ready, exp_rdy[i]);
         end
         tick(); #1;
         checks++;
         if (div_dividend !== (exp_rdy[i][1] ? 24'd30 : 24'd10)) begin
            errors++; $display("FAIL rr_operand[%0d]: dd=%h required %h", i, div_dividend,
                               exp_rdy[i][1] ? 24'd30 : 24'd10);
         end
         tick();
         div_done = 1'b1; div_quotient = 52'd5; div_remainder = 24'd0;
         tick();
         div_done = 1'b0; rsp_ready = 1'b1; #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== exp_rdy[i][1] || req_ready !== 2'b00) begin
            errors++; $display("FAIL rr_resp[%0d]: vld=%b id=%b rdy=%b required 1 %b 00",
                               i, rsp_valid, rsp_id, req_ready, exp_rdy[i][1]);
         end
         tick();
         rsp_ready = 1'b0;
      end
      req_valid = 2'b00;
   endtask

   task automatic test_single_requester();
      do_reset();
      // Grant 0 once so the pointer favours 1, then present only requester 0.
      req_valid = 2'b01;
      tick(); req_valid = 2'b00;
      tick(); div_done = 1'b1;
      tick(); div_done = 1'b0; rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
      req_valid = 2'b01; #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL single_req: rdy=%b required 01", req_ready);
      end
      tick(); req_valid = 2'b00;
      tick(); div_done = 1'b1;
      tick(); div_done = 1'b0; rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
   endtask

   task automatic test_busy();
      do_reset();
      div_busy = 1'b1;
      req_valid = 2'b01; req0_dividend = 24'd9; req0_divisor = 24'd3;
      tick(); req_valid = 2'b00;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (div_en !== 1'b0) begin
            errors++; $display("FAIL busy_hold[%0d]: en=%b required 0", i, div_en);
         end
         tick();
      end
      div_busy = 1'b0; #1;
      checks++;
      if (div_en !== 1'b1) begin
         errors++; $display("FAIL busy_release: en=%b required 1", div_en);
      end
      tick(); #1;
      checks++;
      if (div_en !== 1'b0) begin
         errors++; $display("FAIL busy_single_pulse: en=%b required 0", div_en);
      end
      div_done = 1'b1;
      tick(); div_done = 1'b0; rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
   endtask

   task automatic test_timeout();
      int early = 0;
      do_reset();
      req_valid = 2'b10; req1_dividend = 24'd7; req1_divisor = 24'd1;
      div_quotient = 52'hABC; div_remainder = 24'h12;
      tick(); req_valid = 2'b00;
      tick();                       // first WAIT cycle
      for (int i = 0; i < 64; i++) begin
         #1;
         if (rsp_valid !== 1'b0) early++;
         tick();
      end
      checks++;
      if (early != 0) begin
         errors++; $display("FAIL timeout_early: rsp_valid seen in %0d WAIT cycles, required 0", early);
      end
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_quotient !== 52'd0 ||
          rsp_remainder !== 24'd0 || rsp_id !== 1'b1) begin
         errors++; $display("FAIL timeout_resp: vld=%b err=%b q=%h r=%h id=%b required 1 1 0 0 1",
                            rsp_valid, rsp_err, rsp_quotient, rsp_remainder, rsp_id);
      end
      div_done = 1'b1;
      tick(); div_done = 1'b0; #1;
      checks++;
      if (rsp_quotient !== 52'd0 || rsp_err !== 1'b1) begin
         errors++; $display("FAIL timeout_late_done_resp: q=%h err=%b required 0 1", rsp_quotient, rsp_err);
      end
      rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
      div_done = 1'b1;
      tick(); div_done = 1'b0; #1;
      checks++;
      if (rsp_valid !== 1'b0 || div_en !== 1'b0) begin
         errors++; $display("FAIL timeout_late_done_idle: vld=%b en=%b required 0 0", rsp_valid, div_en);
      end
   endtask

   task automatic test_stall_and_reset();
      int bad = 0;
      do_reset();
      req_valid = 2'b01; req0_dividend = 24'd50; req0_divisor = 24'd7;
      tick(); req_valid = 2'b00;
      tick(); div_done = 1'b1; div_quotient = 52'd7; div_remainder = 24'd1;
      tick(); div_done = 1'b0; div_quotient = '0; div_remainder = '0;
      req_valid = 2'b11;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (rsp_valid !== 1'b1 || rsp_quotient !== 52'd7 || rsp_remainder !== 24'd1 ||
             rsp_err !== 1'b0 || rsp_id !== 1'b0 || req_ready !== 2'b00) bad++;
         tick();
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL stall_stable: %0d unstable cycles, required 0", bad);
      end
      rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
      // Pointer now favours requester 1; grant it and abort in WAIT.
      #1;
      checks++;
      if (req_ready !== 2'b10) begin
         errors++; $display("FAIL stall_next_grant: rdy=%b required 10", req_ready);
      end
      req1_dividend = 24'h111; req1_divisor = 24'h3;
      tick(); req_valid = 2'b00;
      tick(); #1;
      nreset = 1'b0; #1;
      checks++;
      if ({req_ready, div_en, rsp_valid, rsp_err, rsp_id} !== 6'b0 ||
          rsp_quotient !== 52'd0 || rsp_remainder !== 24'd0 ||
          div_dividend !== 24'd0 || div_divisor !== 24'd0) begin
         errors++; $display("FAIL midreset_outputs: rdy=%b en=%b vld=%b dd=%h dv=%h required all zero",
                            req_ready, div_en, rsp_valid, div_dividend, div_divisor);
      end
      tick(); nreset = 1'b1;
      div_done = 1'b1; div_quotient = 52'd99;
      tick(); div_done = 1'b0; #1;
      checks++;
      if (rsp_valid !== 1'b0 || rsp_quotient !== 52'd0) begin
         errors++; $display("FAIL midreset_stale_done: vld=%b q=%h required 0 0", rsp_valid, rsp_quotient);
      end
      // Pointer was reset: with both valid, requester 0 wins.
      req_valid = 2'b11; #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++; $display("FAIL midreset_pointer: rdy=%b required 01", req_ready);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_zero_divisor();
      do_reset();
      req_valid = 2'b01; req0_dividend = 24'h00ABCD; req0_divisor = 24'd0;
      tick(); req_valid = 2'b00; #1;
`ifdef DIV_ZERO_BYPASS_EN
      checks++;
      if (div_en !== 1'b0 || rsp_valid !== 1'b1 || rsp_quotient !== 52'hFFFFFFFFFFFFF ||
          rsp_remainder !== 24'h00ABCD || rsp_err !== 1'b1) begin
         errors++; $display("FAIL zero_bypass: en=%b vld=%b q=%h r=%h err=%b required 0 1 fffffffffffff 00abcd 1",
                            div_en, rsp_valid, rsp_quotient, rsp_remainder, rsp_err);
      end
`else
      checks++;
      if (div_en !== 1'b1 || div_divisor !== 24'd0 || div_dividend !== 24'h00ABCD || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL zero_launch: en=%b dv=%h dd=%h vld=%b required 1 000000 00abcd 0",
                            div_en, div_divisor, div_dividend, rsp_valid);
      end
      tick(); div_done = 1'b1; div_quotient = 52'd3; div_remainder = 24'd4;
      tick(); div_done = 1'b0;
`endif
      rsp_ready = 1'b1;
      tick(); rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_round_robin();
      test_single_requester();
      test_busy();
      test_timeout();
      test_stall_and_reset();
      test_zero_divisor();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
